// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases N_DOM active-low resets in order after PLL lock, re-asserts on lock loss / sw request.
// Optional RST_SEQ_REVERSE_EN: software reset de-sequences domains high-to-low before the hold phase.
module rst_seq_ctrl #(
   parameter int unsigned N_DOM     = 4,
   parameter int unsigned STAGE_DLY = 16,
   parameter int unsigned SW_HOLD   = 32,
   parameter int unsigned LOCK_TMO  = 4096
) (
   input  logic             clk_in,
   input  logic             rstn_in,
   input  logic             pll_locked,
   input  logic             sw_rst_req,
   output logic             sw_rst_ack,
   output logic [N_DOM-1:0] rstn_out,
   output logic             seq_done,
   output logic             lock_err,
   output logic [2:0]       state_o
);

   localparam int unsigned MAX_A   = (STAGE_DLY > SW_HOLD) ? STAGE_DLY : SW_HOLD;
   localparam int unsigned MAX_DLY = (MAX_A > LOCK_TMO) ? MAX_A : LOCK_TMO;
   localparam int unsigned CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
   localparam int unsigned IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_HOLD - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TMO - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOM - 1);
`ifdef RST_SEQ_REVERSE_EN
   localparam logic [IDX_W-1:0] IDX_REV_START = (N_DOM > 1) ? IDX_W'(N_DOM - 2) : '0;
`endif

   typedef enum logic [2:0] {
      S_RST       = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STAGE     = 3'd2,
      S_RUN       = 3'd3,
      S_SW_HOLD   = 3'd4
`ifdef RST_SEQ_REVERSE_EN
      , S_ASSERT  = 3'd5
`endif
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [N_DOM-1:0]   rstn_q, rstn_nxt;
   logic               seq_done_q, seq_done_nxt;
   logic               ack_q, ack_nxt;
   logic               lock_err_q, lock_err_nxt;
   logic               rst_meta;
   logic               lock_meta, lock_sync;

   // Reset release passes rst_meta then the state register, so S_RST exits on the 2nd edge.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         rst_meta  <= 1'b0;
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         rst_meta  <= 1'b1;
         lock_meta <= pll_locked;
         lock_sync <= lock_meta;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state      <= S_RST;
         cnt        <= '0;
         idx        <= '0;
         rstn_q     <= '0;
         seq_done_q <= 1'b0;
         ack_q      <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         rstn_q     <= rstn_nxt;
         seq_done_q <= seq_done_nxt;
         ack_q      <= ack_nxt;
         lock_err_q <= lock_err_nxt;
      end
   end

   // Next-state and next-output logic; lock loss always dominates a software request.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      idx_nxt      = idx;
      rstn_nxt     = rstn_q;
      seq_done_nxt = 1'b0;
      ack_nxt      = 1'b0;
      lock_err_nxt = lock_err_q;

      case (state)
         S_RST: begin
            rstn_nxt = '0;
            cnt_nxt  = '0;
            idx_nxt  = '0;
            if (rst_meta) state_nxt = S_WAIT_LOCK;
         end

         S_WAIT_LOCK: begin
            rstn_nxt = '0;
            idx_nxt  = '0;
            if (lock_sync) begin
               state_nxt = S_STAGE;
               cnt_nxt   = '0;
            end else if (cnt == TMO_LAST) begin
               lock_err_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_STAGE: begin
            if (!lock_sync) begin
               state_nxt = S_WAIT_LOCK;
               rstn_nxt  = '0;
               cnt_nxt   = '0;
            end else if (cnt == STAGE_LAST) begin
               rstn_nxt[idx] = 1'b1;
               cnt_nxt       = '0;
               if (idx == IDX_LAST) begin
                  state_nxt    = S_RUN;
                  seq_done_nxt = 1'b1;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_RUN: begin
            if (!lock_sync) begin
               state_nxt = S_WAIT_LOCK;
               rstn_nxt  = '0;
               cnt_nxt   = '0;
            end else if (sw_rst_req) begin
               ack_nxt = 1'b1;
               cnt_nxt = '0;
`ifdef RST_SEQ_REVERSE_EN
               rstn_nxt[N_DOM-1] = 1'b0;
               if (N_DOM == 1) begin
                  state_nxt = S_SW_HOLD;
               end else begin
                  state_nxt = S_ASSERT;
                  idx_nxt   = IDX_REV_START;
               end
`else
               rstn_nxt  = '0;
               state_nxt = S_SW_HOLD;
`endif
            end else begin
               seq_done_nxt = 1'b1;
            end
         end

         S_SW_HOLD: begin
            rstn_nxt = '0;
            if (!lock_sync) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

`ifdef RST_SEQ_REVERSE_EN
         // Reverse de-sequence: idx is the next bit to clear
         S_ASSERT: begin
            if (!lock_sync) begin
               state_nxt = S_WAIT_LOCK;
               rstn_nxt  = '0;
               cnt_nxt   = '0;
            end else if (cnt == STAGE_LAST) begin
               rstn_nxt[idx] = 1'b0;
               cnt_nxt       = '0;
               if (idx == '0) state_nxt = S_SW_HOLD;
               else           idx_nxt   = idx - IDX_W'(1);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`endif

         default: begin
            state_nxt = S_WAIT_LOCK;
            rstn_nxt  = '0;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   assign rstn_out   = rstn_q;
   assign seq_done   = seq_done_q;
   assign sw_rst_ack = ack_q;
   assign lock_err   = lock_err_q;
   assign state_o    = state;

endmodule
